// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : Turns a UART byte stream into checksummed register-write bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 4340
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_valid,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [2:0]  last_err,
  output logic [15:0] err_count,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_ADDR  = 3'd2,
    S_LEN   = 3'd3,
    S_DATA  = 3'd4,
    S_CSUM  = 3'd5,
    S_DRAIN = 3'd6
  } state_t;

  localparam logic [7:0]  c_SYNC        = 8'hA5;
  localparam logic [7:0]  c_CMD_INC     = 8'h01;
  localparam logic [7:0]  c_CMD_FIX     = 8'h02;
  localparam logic [7:0]  c_MAX_LEN     = 8'(MAX_LEN);
  localparam logic [31:0] c_TIMEOUT     = 32'(TIMEOUT);
  localparam logic [2:0]  c_ERR_CMD     = 3'd1;
  localparam logic [2:0]  c_ERR_LEN     = 3'd2;
  localparam logic [2:0]  c_ERR_CSUM    = 3'd3;
  localparam logic [2:0]  c_ERR_TIMEOUT = 3'd4;
  localparam int          c_AW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cmd, r_addr, r_len, r_idx, r_xor;
  logic [7:0]  r_buf [0:(1<<c_AW)-1];
  logic [31:0] r_timer;
  logic        r_frame_err;
  logic [2:0]  r_last_err;
  logic [15:0] r_err_count;
  logic        r_overrun;

  logic        w_abort, w_buf_we, w_ld_cmd, w_ld_addr, w_ld_len;
  logic [2:0]  w_abort_code;
  logic [7:0]  w_idx_nxt, w_xor_nxt;
  logic        w_in_frame, w_timeout, w_wr_valid, w_accept, w_done;

  assign w_in_frame = (r_state == S_CMD)  || (r_state == S_ADDR) || (r_state == S_LEN) ||
                      (r_state == S_DATA) || (r_state == S_CSUM);
  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign w_timeout  = w_in_frame && !rx_valid && (r_timer == c_TIMEOUT);
  assign w_wr_valid = (r_state == S_DRAIN) && (r_idx < r_len);
  assign w_accept   = w_wr_valid && wr_ready;
  assign w_done     = (r_state == S_DRAIN) && (r_idx == r_len);

  always_comb begin
    w_state_nxt  = r_state;
    w_abort      = 1'b0;
    w_abort_code = 3'd0;
    w_buf_we     = 1'b0;
    w_ld_cmd     = 1'b0;
    w_ld_addr    = 1'b0;
    w_ld_len     = 1'b0;
    w_idx_nxt    = r_idx;
    w_xor_nxt    = r_xor;
    case (r_state)
      S_IDLE: begin
        if (rx_valid && rx_data == c_SYNC) w_state_nxt = S_CMD;
      end
      S_CMD: begin
        if (rx_valid) begin
          if (rx_data == c_CMD_INC || rx_data == c_CMD_FIX) begin
            w_ld_cmd    = 1'b1;
            w_xor_nxt   = rx_data;
            w_state_nxt = S_ADDR;
          end else begin
            w_abort      = 1'b1;
            w_abort_code = c_ERR_CMD;
          end
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          w_ld_addr   = 1'b1;
          w_xor_nxt   = r_xor ^ rx_data;
          w_state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_valid) begin
          if (rx_data > c_MAX_LEN) begin
            w_abort      = 1'b1;
            w_abort_code = c_ERR_LEN;
          end else begin
            w_ld_len    = 1'b1;
            w_xor_nxt   = r_xor ^ rx_data;
            w_idx_nxt   = 8'd0;
            w_state_nxt = (rx_data == 8'd0) ? S_CSUM : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          w_buf_we  = 1'b1;
          w_xor_nxt = r_xor ^ rx_data;
          w_idx_nxt = r_idx + 8'd1;
          if (r_idx + 8'd1 == r_len) w_state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == r_xor) begin
            w_idx_nxt   = 8'd0;
            w_state_nxt = S_DRAIN;
          end else begin
            w_abort      = 1'b1;
            w_abort_code = c_ERR_CSUM;
          end
        end
      end
      S_DRAIN: begin
        if (w_accept) w_idx_nxt = r_idx + 8'd1;
        if (w_done)   w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) begin
      w_abort      = 1'b1;
      w_abort_code = c_ERR_TIMEOUT;
    end
    if (w_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd       <= 8'd0;
      r_addr      <= 8'd0;
      r_len       <= 8'd0;
      r_idx       <= 8'd0;
      r_xor       <= 8'd0;
      r_timer     <= 32'd0;
      r_frame_err <= 1'b0;
      r_last_err  <= 3'd0;
      r_err_count <= 16'd0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_xor       <= w_xor_nxt;
      r_frame_err <= w_abort;
      if (w_ld_cmd)  r_cmd  <= rx_data;
      if (w_ld_addr) r_addr <= rx_data;
      if (w_ld_len)  r_len  <= rx_data;
      if (rx_valid || w_state_nxt == S_IDLE) r_timer <= 32'd0;
      else                                   r_timer <= r_timer + 32'd1;
      if (w_abort) begin
        r_last_err <= w_abort_code;
        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
      end else if (w_done) begin
        r_last_err <= 3'd0;
      end
      if (r_state == S_DRAIN && rx_valid) r_overrun <= 1'b1;
    end
  end

  // Payload storage carries no reset; outputs are gated so stale data never shows.
  always_ff @(posedge clk) begin
    if (w_buf_we) r_buf[r_idx[c_AW-1:0]] <= rx_data;
  end

  assign wr_valid  = w_wr_valid;
  assign wr_addr   = w_wr_valid ? ((r_cmd == c_CMD_INC) ? r_addr + r_idx : r_addr) : 8'd0;
  assign wr_data   = w_wr_valid ? r_buf[r_idx[c_AW-1:0]] : 8'd0;
  assign frame_ok  = w_done;
  assign frame_err = r_frame_err;
  assign last_err  = r_last_err;
  assign err_count = r_err_count;
  assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_ctrl
// Description : Directed and randomized frame stimulus for uart_cmd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;
  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 4340;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_valid;
  logic [7:0]  wr_addr, wr_data;
  logic        wr_ready;
  logic        frame_ok, frame_err;
  logic [2:0]  last_err;
  logic [15:0] err_count;
  logic        overrun;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .frame_ok(frame_ok), .frame_err(frame_err), .last_err(last_err),
    .err_count(err_count), .overrun(overrun)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  int          ok_pulses = 0, err_pulses = 0;
  int          exp_ok = 0, exp_errp = 0;
  int          exp_err_count = 0;
  logic [2:0]  exp_last = 3'd0;
  logic        exp_ovr = 1'b0;
  logic [7:0]  pl [256];
  int          ready_mode = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = held low, 2 = random
  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      wr_ready = (ready_mode == 0) ? 1'b1 :
                 (ready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Bus monitor: collects accepted writes, counts pulses, checks hold-under-stall
  logic       prev_stall = 1'b0;
  logic [7:0] prev_a, prev_d;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold_stable", {wr_valid, wr_addr, wr_data}, {1'b1, prev_a, prev_d});
      if (wr_valid && wr_ready) obs_q.push_back({wr_addr, wr_data});
      if (frame_ok)  ok_pulses++;
      if (frame_err) err_pulses++;
      prev_stall = wr_valid && !wr_ready;
      prev_a     = wr_addr;
      prev_d     = wr_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  // Expected outcome of one frame: kind 0 = good, otherwise the abort code
  task automatic expect_frame(input int kind, input logic [7:0] cmd, input logic [7:0] addr,
                              input int len);
    if (kind == 0) begin
      for (int i = 0; i < len; i++)
        exp_q.push_back({(cmd == 8'h01) ? 8'(int'(addr) + i) : addr, pl[i]});
      exp_ok++;
      exp_last = 3'd0;
    end else begin
      exp_errp++;
      exp_last = 3'(kind);
      if (exp_err_count < 65535) exp_err_count++;
    end
  endtask

  task automatic send_frame(input int kind, input logic [7:0] cmd, input logic [7:0] addr,
                            input int len, input logic [7:0] flip, input int gapmax);
    logic [7:0] cs;
    cs = cmd ^ addr ^ 8'(len);
    if (len <= MAX_LEN)
      for (int i = 0; i < len; i++) cs ^= pl[i];
    send_byte(8'hA5); tick($urandom_range(0, gapmax));
    send_byte(cmd);
    if (kind == 1) return;
    tick($urandom_range(0, gapmax));
    send_byte(addr);  tick($urandom_range(0, gapmax));
    send_byte(8'(len));
    if (kind == 2) return;
    for (int i = 0; i < len; i++) begin
      tick($urandom_range(0, gapmax));
      send_byte(pl[i]);
    end
    tick($urandom_range(0, gapmax));
    send_byte(cs ^ flip);
  endtask

  task automatic wait_event(input string tag, input int budget);
    int ok0, er0, n;
    ok0 = ok_pulses;
    er0 = err_pulses;
    n   = 0;
    while (ok_pulses == ok0 && err_pulses == er0 && n < budget) begin
      tick(1);
      n++;
    end
    check({tag, "_in_time"}, 64'(n < budget), 64'd1);
  endtask

  task automatic frame_check(input string tag);
    check({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_wr"}, 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
    check({tag, "_okp"},   64'(ok_pulses),  64'(exp_ok));
    check({tag, "_errp"},  64'(err_pulses), 64'(exp_errp));
    check({tag, "_last"},  64'(last_err),   64'(exp_last));
    check({tag, "_ecnt"},  64'(err_count),  64'(exp_err_count));
    check({tag, "_ovr"},   64'(overrun),    64'(exp_ovr));
  endtask

  task automatic load_case1;
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c, a, g;
    int k, len, n;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(2);
    check("reset_outputs", {wr_valid, wr_addr, wr_data, frame_ok, frame_err, last_err, err_count, overrun}, 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Case 1: good incrementing frame, checks latency and frame_ok timing
    load_case1();
    expect_frame(0, 8'h01, 8'h10, 3);
    send_frame(0, 8'h01, 8'h10, 3, 8'h00, 0);
    check("c1_latency", {wr_valid, wr_addr, wr_data}, {1'b1, 8'h10, 8'h11});
    tick(3);
    check("c1_frame_ok", {frame_ok, wr_valid}, 2'b10);
    tick(1);
    check("c1_ok_single", 64'(frame_ok), 64'd0);
    tick(1);
    frame_check("c1");

    // Case 2: bad checksum
    expect_frame(3, 8'h01, 8'h10, 3);
    send_frame(3, 8'h01, 8'h10, 3, 8'h01, 0);
    wait_event("c2", 50);
    tick(2);
    frame_check("c2");

    // Case 3: stall with address wrap
    pl[0] = 8'hAA; pl[1] = 8'hBB;
    ready_mode = 1;
    expect_frame(0, 8'h01, 8'hFF, 2);
    send_frame(0, 8'h01, 8'hFF, 2, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      check("c3_stall", {wr_valid, wr_addr, wr_data}, {1'b1, 8'hFF, 8'hAA});
      tick(1);
    end
    ready_mode = 0;
    wait_event("c3", 50);
    tick(2);
    frame_check("c3");

    // Case 4: timeout boundary, then a byte landing exactly on the expiry cycle
    send_byte(8'hA5); send_byte(8'h01);
    tick(TIMEOUT);
    check("c4_not_yet", 64'(frame_err), 64'd0);
    tick(1);
    check("c4_timeout", 64'(frame_err), 64'd1);
    expect_frame(4, 8'h01, 8'h00, 0);
    tick(2);
    frame_check("c4a");
    pl[0] = 8'hAA; pl[1] = 8'hBB;
    expect_frame(0, 8'h02, 8'hFE, 2);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hFE);
    tick(TIMEOUT);
    send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hEF);
    wait_event("c4b", 50);
    tick(2);
    frame_check("c4b");

    // Case 5: bad command and oversize length
    expect_frame(1, 8'h07, 8'h00, 0);
    send_frame(1, 8'h07, 8'h00, 0, 8'h00, 0);
    wait_event("c5a", 20);
    tick(2);
    frame_check("c5a");
    expect_frame(2, 8'h01, 8'h00, MAX_LEN + 1);
    send_frame(2, 8'h01, 8'h00, MAX_LEN + 1, 8'h00, 0);
    wait_event("c5b", 20);
    tick(2);
    frame_check("c5b");

    // Zero-length frame
    expect_frame(0, 8'h02, 8'h33, 0);
    send_frame(0, 8'h02, 8'h33, 0, 8'h00, 0);
    check("len0_frame_ok", {frame_ok, wr_valid}, 2'b10);
    tick(3);
    frame_check("len0");

    // Overrun: a byte arriving while writes are stalled is dropped
    load_case1();
    ready_mode = 1;
    expect_frame(0, 8'h01, 8'h10, 3);
    send_frame(0, 8'h01, 8'h10, 3, 8'h00, 0);
    send_byte(8'h5A);
    exp_ovr = 1'b1;
    check("ovr_set", {overrun, wr_valid, wr_addr, wr_data}, {2'b11, 8'h10, 8'h11});
    ready_mode = 0;
    wait_event("ovr", 50);
    tick(2);
    frame_check("ovr");

    // Reset mid-DATA: outputs clear immediately, without a clock edge
    send_byte(8'h00); send_byte(8'h55);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10); send_byte(8'h03); send_byte(8'h11);
    rst_n = 1'b0;
    #1;
    check("async_reset", {wr_valid, wr_addr, wr_data, frame_ok, frame_err, last_err, err_count, overrun}, 64'd0);
    tick(2);
    rst_n = 1'b1;
    exp_err_count = 0; exp_last = 3'd0; exp_ovr = 1'b0;
    obs_q.delete();
    tick(1);
    send_byte(8'h00); send_byte(8'h55);
    load_case1();
    expect_frame(0, 8'h01, 8'h10, 3);
    send_frame(0, 8'h01, 8'h10, 3, 8'h00, 0);
    wait_event("post_rst", 50);
    tick(2);
    frame_check("post_rst");

    // Randomized frames with random backpressure, gaps and leading noise
    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send_byte(g);
      end
      k = $urandom_range(0, 9);
      k = (k <= 2) ? k + 1 : 0;
      c = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h02;
      if (k == 1) begin
        c = 8'($urandom_range(3, 255));
      end
      a   = 8'($urandom_range(0, 255));
      len = (k == 2) ? $urandom_range(MAX_LEN + 1, 255) : $urandom_range(0, MAX_LEN);
      for (int j = 0; j < MAX_LEN; j++) pl[j] = 8'($urandom_range(0, 255));
      expect_frame(k, c, a, len);
      send_frame(k, c, a, len, (k == 3) ? 8'($urandom_range(1, 255)) : 8'h00, 2);
      wait_event("rnd", 1000);
      tick(2);
      frame_check("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Command-frame controller that sits directly after the UART receiver and sequences its byte stream into register-write bursts. It hunts for a sync byte, parses a header, buffers up to MAX_LEN payload bytes and verifies an XOR checksum. Only after the checksum passes does it replay the payload as write transactions on a valid/ready register bus. It also enforces an inter-byte timeout and reports errors, so a host link can configure on-chip registers over a single serial line.

Parameters:
MAX_LEN, 16, maximum payload bytes per frame (1..255); sets the payload buffer depth.
TIMEOUT, 4340, clk cycles allowed between received bytes inside a frame (about 20 bit times at 115200 baud from 25 MHz).

Ports:
clk  input  1  system clock; all logic on posedge.
rst_n  input  1  asynchronous, active-low reset.
rx_data  input  8  byte from the UART receiver; valid only when rx_valid is high.
rx_valid  input  1  single-cycle strobe, one per received byte; no backpressure.
wr_valid  output  1  write request.
wr_addr  output  8  write address.
wr_data  output  8  write data.
wr_ready  input  1  write accepted on a posedge where wr_valid and wr_ready are both high.
frame_ok  output  1  one-cycle pulse when a frame's last write has been accepted.
frame_err  output  1  one-cycle pulse when a frame is aborted.
last_err  output  3  code of the most recent abort: 0 none, 1 bad cmd, 2 length, 3 checksum, 4 timeout.
err_count  output  16  aborted-frame count, saturating at 0xFFFF.
overrun  output  1  sticky flag; set if rx_valid arrives during DRAIN.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. rst_n low forces state to IDLE and every output to 0, immediately and regardless of clk. The buffer contents need no reset.
- Frame format: 0xA5, CMD, ADDR, LEN, LEN payload bytes, CSUM.
  - CSUM must equal the XOR of CMD, ADDR, LEN and all payload bytes.
  - CMD 0x01: incrementing-address write; the address wraps from 0xFF to 0x00.
  - CMD 0x02: fixed-address write.
- States: IDLE, CMD, ADDR, LEN, DATA, CSUM, DRAIN.
- IDLE: on rx_valid with 0xA5, go to CMD. Any other byte is ignored silently; this is not an error.
- CMD: a byte not equal to 0x01 or 0x02 aborts with code 1. Otherwise store the byte, seed the running XOR with it, and go to ADDR.
- ADDR: store the byte, XOR it in, go to LEN.
- LEN:
  - LEN > MAX_LEN aborts with code 2.
  - LEN = 0 goes to CSUM.
  - Otherwise go to DATA.
- DATA: write each byte to buf[index], XOR it in, and increment index. Go to CSUM after LEN bytes.
- CSUM: on match go to DRAIN with index = 0. On mismatch abort with code 3; no write is issued.
- DRAIN:
  - wr_valid is high while index < LEN.
  - wr_addr = ADDR + index for CMD 0x01, or ADDR for CMD 0x02 (8-bit arithmetic).
  - wr_data = buf[index].
  - wr_addr and wr_data hold stable until accepted. After an accept, the next write is presented on the following cycle, so back-to-back writes are allowed.
  - The cycle after the last accept: wr_valid = 0, frame_ok pulses, state returns to IDLE.
  - With LEN = 0, frame_ok pulses the cycle after entering DRAIN and no write is issued.
- rx_valid in DRAIN: the byte is dropped and overrun is set. overrun is cleared only by reset.
- Timeout:
  - A 32-bit counter clears on every rx_valid and on entry to IDLE, and increments otherwise.
  - In CMD, ADDR, LEN, DATA or CSUM, counter == TIMEOUT aborts with code 4.
  - The timer is not active in IDLE or DRAIN.
  - If rx_valid and the timeout coincide, the byte wins: it is processed and the counter clears.
- Abort: return to IDLE; pulse frame_err for one cycle; latch last_err; increment err_count (saturating).
- A frame_ok that follows an abort resets last_err to 0.
- A 0xA5 byte arriving mid-frame is treated as ordinary data; there is no resynchronisation.
- Latency: the first wr_valid rises in the cycle after the CSUM byte's rx_valid.

Test Plan:
1. Send A5 01 10 03 11 22 33 12 with wr_ready = 1 -> writes (0x10,0x11), (0x11,0x22), (0x12,0x33) on consecutive cycles; frame_ok pulses one cycle after the third accept; err_count = 0.
2. Send the same frame with CSUM 0x13 -> no wr_valid; frame_err pulse; last_err = 3; err_count = 1.
3. Send A5 01 FF 02 AA BB ED, holding wr_ready low 5 cycles -> wr_valid, addr 0xFF and data 0xAA are stable for all 5 cycles; then writes (0xFF,0xAA), (0x00,0xBB); frame_ok pulses.
4. Send A5 01 followed by TIMEOUT idle cycles -> frame_err and last_err = 4. Then send A5 02 FE 02 AA BB EF -> writes (0xFE,0xAA), (0xFE,0xBB); frame_ok; last_err = 0.
5. Send A5 07 -> last_err = 1. Send A5 01 00 11 (LEN 17) -> last_err = 2. Result: err_count = 2, and no write occurs.
6. Send 00 55, then a frame; drop rst_n mid-DATA, then release it -> the leading bytes are ignored; all outputs are 0 immediately on reset; the next valid frame from case 1 completes correctly. A byte sent during DRAIN -> overrun = 1.
